sw_debouncer: RTL

- Upstream conditioning stage for the LED test top: takes the raw board slide switches and drives the top's i_sw bus.
- Per bit: two-flop synchronizer to the clock, then a stability-counter FSM. A new level is accepted only after it has been stable for DEBOUNCE_CYCLES cycles.
- Also emits one-cycle rise and fall pulses per switch, so downstream logic can react to edges instead of levels.

---
 rtl/sw_debouncer_pkg.sv | 16 +
 rtl/sw_debounce_cell.sv | 126 ++++++++++++
 rtl/sw_debouncer.sv | 33 +++
 3 files changed

// File: rtl/sw_debouncer_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and the
// default debounce timing constants that benches can also pull in.
package sw_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b11,
    ST_WAIT_LOW  = 2'b10
  } sw_state_e;

  localparam int DEFAULT_NB_SW           = 4;
  localparam int DEFAULT_NB_DEBOUNCE     = 20;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;  // 10 ms at 100 MHz

endpackage : sw_debouncer_pkg

// File: rtl/sw_debounce_cell.sv
// One switch bit: two-flop synchronizer, stability-counter FSM and
// registered rise/fall pulses.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_LOW       | debounced level 0, input agrees
//   ST_WAIT_HIGH | debounced level 0, input has been 1 for cnt samples
//   ST_HIGH      | debounced level 1, input agrees
//   ST_WAIT_LOW  | debounced level 1, input has been 0 for cnt samples
module sw_debounce_cell
  import sw_debouncer_pkg::*;
#(
  parameter int NB_DEBOUNCE     = DEFAULT_NB_DEBOUNCE,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw_raw,
  output logic o_sw,
  output logic o_sw_rise,
  output logic o_sw_fall
);

  // Terminal count: the DEBOUNCE_CYCLES-th stable sample is seen while cnt
  // holds DEBOUNCE_CYCLES-1, since the first stable sample loads cnt=1.
  localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_DEBOUNCE-1:0] CNT_ONE  = NB_DEBOUNCE'(1);

  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  sw_state_e              state_q, state_d;
  logic [NB_DEBOUNCE-1:0] cnt_q, cnt_d;
  logic                   sw_q, sw_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync1_d = i_sw_raw;
  assign sync2_d = sync1_q;

  // State register plus all datapath flops; async assert, sync release.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state: a disagreeing sample starts a wait, any agreeing sample aborts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOW: begin
        if (sync2_q) state_d = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (!sync2_q)               state_d = ST_LOW;
        else if (cnt_q == CNT_LAST) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (!sync2_q) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (sync2_q)                state_d = ST_HIGH;
        else if (cnt_q == CNT_LAST) state_d = ST_LOW;
      end
      default: state_d = ST_LOW;
    endcase
  end

  // Counter, debounced level and edge pulses; the counter never passes CNT_LAST.
  always_comb begin
    cnt_d  = '0;
    sw_d   = sw_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        sw_d = 1'b0;
        if (sync2_q) cnt_d = CNT_ONE;
      end
      ST_WAIT_HIGH: begin
        if (sync2_q) begin
          if (cnt_q == CNT_LAST) begin
            sw_d   = 1'b1;
            rise_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_HIGH: begin
        sw_d = 1'b1;
        if (!sync2_q) cnt_d = CNT_ONE;
      end
      ST_WAIT_LOW: begin
        if (!sync2_q) begin
          if (cnt_q == CNT_LAST) begin
            sw_d   = 1'b0;
            fall_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: sw_d = 1'b0;
    endcase
  end

  assign o_sw      = sw_q;
  assign o_sw_rise = rise_q;
  assign o_sw_fall = fall_q;

endmodule : sw_debounce_cell

// File: rtl/sw_debouncer.sv
// Debounces the raw board slide switches into the LED test top's i_sw bus.
// Every bit has its own synchronizer and counter; bits never interact.
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int NB_SW           = DEFAULT_NB_SW,
  parameter int NB_DEBOUNCE     = DEFAULT_NB_DEBOUNCE,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw_raw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_sw_rise,
  output logic [NB_SW-1:0] o_sw_fall
);

  // One independent cell per switch bit.
  for (genvar g = 0; g < NB_SW; g++) begin : g_cell
    sw_debounce_cell #(
      .NB_DEBOUNCE     (NB_DEBOUNCE),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_sw_raw  (i_sw_raw[g]),
      .o_sw      (o_sw[g]),
      .o_sw_rise (o_sw_rise[g]),
      .o_sw_fall (o_sw_fall[g])
    );
  end

endmodule : sw_debouncer
